frame_buf_ctrl: RTL

Double-buffer (ping-pong) frame controller that sits directly upstream of the display frame multiplexer. It generates the one-hot SelBuf0/SelBlank/SelBuf1 selects, the read pixel address and the line/frame raster counts. It also arbitrates buffer swaps with the frame writer, so a swap occurs only at a frame boundary and a frame never tears.

---
 rtl/frame_buf_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/frame_buf_ctrl.sv
// frame_buf_ctrl: ping-pong frame buffer raster controller with tear-free swap arbitration
module frame_buf_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 45,
  parameter int ADDR_W   = 19
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Enable,
  input  logic              WrDone,
  output logic              SelBuf0,
  output logic              SelBlank,
  output logic              SelBuf1,
  output logic [ADDR_W-1:0] RdAddr,
  output logic              WrBuf,
  output logic              BackReady,
  output logic              SwapAck,
  output logic              FrameStart
);
  localparam int HT = H_ACTIVE + H_BLANK;
  localparam int VT = V_ACTIVE + V_BLANK;
  localparam int HW = $clog2(HT + 1);
  localparam int VW = $clog2(VT + 1);
  typedef enum logic {IDLE, PEND} state_t;
  state_t            state, state_nx;
  logic              front, front_nx;
  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic              h_last, v_last, frame_end, origin, act, swap;
  logic [ADDR_W-1:0] rd_nx;
  assign h_last    = hcnt == HW'(HT - 1);
  assign v_last    = vcnt == VW'(VT - 1);
  assign frame_end = Enable && h_last && v_last;
  assign origin    = hcnt == '0 && vcnt == '0;
  assign act       = Enable && hcnt < HW'(H_ACTIVE) && vcnt < VW'(V_ACTIVE);
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= (!Enable || h_last) ? '0 : hcnt + 1'b1;
      vcnt <= !Enable ? '0 : !h_last ? vcnt : v_last ? '0 : vcnt + 1'b1;
    end
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      front <= 1'b0;
    end else begin
      state <= state_nx;
      front <= front_nx;
    end
  end
  // a WrDone landing on the frame-end cycle swaps at once instead of pending a whole frame
  always_comb begin
    state_nx = (state == IDLE) ? ((WrDone && !frame_end) ? PEND : IDLE)
                               : (frame_end ? IDLE : PEND);
  end
  always_comb begin
    swap     = frame_end && (state == PEND || WrDone);
    front_nx = front ^ swap;
    rd_nx    = !act ? RdAddr : origin ? '0 : RdAddr + 1'b1;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      SelBuf0    <= 1'b0;
      SelBlank   <= 1'b1;
      SelBuf1    <= 1'b0;
      RdAddr     <= '0;
      WrBuf      <= 1'b1;
      BackReady  <= 1'b1;
      SwapAck    <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      SelBuf0    <= act && !front;
      SelBlank   <= !act;
      SelBuf1    <= act && front;
      RdAddr     <= rd_nx;
      WrBuf      <= !front_nx;
      BackReady  <= state_nx == IDLE;
      SwapAck    <= swap;
      FrameStart <= Enable && origin;
    end
  end
endmodule
